// File: rtl/fp_exec_pkg.sv
// fp_exec_pkg: shared types and constants for the FP execute-stage helpers.
`default_nettype none

package fp_exec_pkg;

  localparam int REQ_ID_W  = 1;
  localparam logic [REQ_ID_W-1:0] REQ_MAIN = 1'b0;
  localparam logic [REQ_ID_W-1:0] REQ_AUX  = 1'b1;

  localparam int FP_W      = 32;
  localparam int PROD_W    = 64;
  // Widest tag any user may carry; narrower tags are zero-extended into it.
  localparam int TAG_MAX_W = 16;

  typedef struct packed {
    logic                 valid;
    logic [REQ_ID_W-1:0]  owner;
    logic [TAG_MAX_W-1:0] tag;
  } tp_entry_t;

endpackage

`default_nettype wire

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: two-way round-robin arbiter with a per-requester mask; the
// most recently granted requester loses the next contention.
`default_nettype none

module rr_arbiter2
  import fp_exec_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] req_i,
  input  logic [1:0] mask_i,
  output logic [1:0] gnt_o
);

  logic [REQ_ID_W-1:0] last_q;
  logic [1:0]          elig;

  assign elig = req_i & ~mask_i;

  always_comb begin
    gnt_o = elig;
    if (&elig) gnt_o = (last_q == REQ_MAIN) ? 2'b10 : 2'b01;
  end

  // Resetting to the aux id lets the main path win the first contention.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)      last_q <= REQ_AUX;
    else if (|elig)  last_q <= gnt_o[1];
  end

endmodule

`default_nettype wire

// File: rtl/fmul_scheduler.sv
// fmul_scheduler: shares one pipelined FP multiplier between two requesters,
// tracking owner/tag per in-flight op and routing products back to the owner.
`default_nettype none

module fmul_scheduler
  import fp_exec_pkg::*;
#(
  parameter int MUL_LATENCY = 3,
  parameter int TAG_W       = 5
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req0_valid_i,
  output logic              req0_ready_o,
  input  logic [FP_W-1:0]   req0_op1_i,
  input  logic [FP_W-1:0]   req0_op2_i,
  input  logic [TAG_W-1:0]  req0_tag_i,
  input  logic              req1_valid_i,
  output logic              req1_ready_o,
  input  logic [FP_W-1:0]   req1_op1_i,
  input  logic [FP_W-1:0]   req1_op2_i,
  input  logic [TAG_W-1:0]  req1_tag_i,
  input  logic              flush_i,
  output logic              mul_start_o,
  output logic [FP_W-1:0]   mul_op1_o,
  output logic [FP_W-1:0]   mul_op2_o,
  input  logic [PROD_W-1:0] mul_result_i,
  output logic              res0_valid_o,
  output logic [PROD_W-1:0] res0_data_o,
  output logic [TAG_W-1:0]  res0_tag_o,
  output logic              res1_valid_o,
  output logic [PROD_W-1:0] res1_data_o,
  output logic [TAG_W-1:0]  res1_tag_o,
  output logic              busy_o,
  output logic [3:0]        inflight_cnt_o
);

  logic [1:0] gnt;

  rr_arbiter2 u_arb (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .req_i  ({req1_valid_i, req0_valid_i}),
    .mask_i ({1'b0, flush_i}),
    .gnt_o  (gnt)
  );

  assign req0_ready_o = gnt[0];
  assign req1_ready_o = gnt[1];
  assign mul_start_o  = |gnt;

  logic [FP_W-1:0]  op1_sel, op2_sel, op1_q, op2_q;
  logic [TAG_W-1:0] tag_sel;

  always_comb begin
    op1_sel = gnt[1] ? req1_op1_i : req0_op1_i;
    op2_sel = gnt[1] ? req1_op2_i : req0_op2_i;
    tag_sel = gnt[1] ? req1_tag_i : req0_tag_i;
  end

  // Operands hold their last launched value while idle to avoid toggling.
  assign mul_op1_o = mul_start_o ? op1_sel : op1_q;
  assign mul_op2_o = mul_start_o ? op2_sel : op2_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      op1_q <= '0;
      op2_q <= '0;
    end else if (mul_start_o) begin
      op1_q <= op1_sel;
      op2_q <= op2_sel;
    end
  end

  tp_entry_t  pipe_q [MUL_LATENCY];
  tp_entry_t  pipe_d [MUL_LATENCY];
  logic [3:0] cnt_d, cnt_q;

  always_comb begin
    pipe_d[0].valid = mul_start_o;
    pipe_d[0].owner = gnt[1];
    pipe_d[0].tag   = TAG_MAX_W'(tag_sel);
    for (int i = 1; i < MUL_LATENCY; i++) begin
      pipe_d[i] = pipe_q[i-1];
      if (flush_i && (pipe_q[i-1].owner == REQ_MAIN)) pipe_d[i].valid = 1'b0;
    end
    cnt_d = '0;
    for (int i = 0; i < MUL_LATENCY; i++) cnt_d = cnt_d + 4'(pipe_d[i].valid);
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 0; i < MUL_LATENCY; i++) pipe_q[i] <= '0;
      cnt_q <= '0;
    end else begin
      for (int i = 0; i < MUL_LATENCY; i++) pipe_q[i] <= pipe_d[i];
      cnt_q <= cnt_d;
    end
  end

  // The last stage lines up with the cycle mul_result_i carries its product.
  logic ret0, ret1;
  assign ret0 = pipe_q[MUL_LATENCY-1].valid && (pipe_q[MUL_LATENCY-1].owner == REQ_MAIN) && !flush_i;
  assign ret1 = pipe_q[MUL_LATENCY-1].valid && (pipe_q[MUL_LATENCY-1].owner == REQ_AUX);

  logic              res0_valid_q, res1_valid_q;
  logic [PROD_W-1:0] res0_data_q, res1_data_q;
  logic [TAG_W-1:0]  res0_tag_q, res1_tag_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      res0_valid_q <= 1'b0;
      res0_data_q  <= '0;
      res0_tag_q   <= '0;
      res1_valid_q <= 1'b0;
      res1_data_q  <= '0;
      res1_tag_q   <= '0;
    end else begin
      res0_valid_q <= ret0;
      res1_valid_q <= ret1;
      if (ret0) begin
        res0_data_q <= mul_result_i;
        res0_tag_q  <= pipe_q[MUL_LATENCY-1].tag[TAG_W-1:0];
      end
      if (ret1) begin
        res1_data_q <= mul_result_i;
        res1_tag_q  <= pipe_q[MUL_LATENCY-1].tag[TAG_W-1:0];
      end
    end
  end

  assign res0_valid_o   = res0_valid_q;
  assign res0_data_o    = res0_data_q;
  assign res0_tag_o     = res0_tag_q;
  assign res1_valid_o   = res1_valid_q;
  assign res1_data_o    = res1_data_q;
  assign res1_tag_o     = res1_tag_q;
  assign inflight_cnt_o = cnt_q;
  assign busy_o         = (cnt_q != 4'd0) | res0_valid_q | res1_valid_q;

endmodule

`default_nettype wire

// File: tb/tb_fmul_scheduler.sv
// tb_fmul_scheduler: directed, table-driven bench with a behavioural
// fixed-latency multiplier (64-bit unsigned product of the two operands).
`default_nettype none

module tb_fmul_scheduler;

  localparam int LAT = 3;
  localparam int TW  = 5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        v0, v1, flush;
  logic        rdy0, rdy1;
  logic [31:0] a0, b0, a1, b1;
  logic [TW-1:0] t0, t1;
  logic        start;
  logic [31:0] mop1, mop2;
  logic [63:0] mres;
  logic        r0v, r1v, busy;
  logic [63:0] r0d, r1d;
  logic [TW-1:0] r0t, r1t;
  logic [3:0]  cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fmul_scheduler #(.MUL_LATENCY(LAT), .TAG_W(TW)) dut (
    .clk_i(clk), .rst_i(rst_n),
    .req0_valid_i(v0), .req0_ready_o(rdy0), .req0_op1_i(a0), .req0_op2_i(b0), .req0_tag_i(t0),
    .req1_valid_i(v1), .req1_ready_o(rdy1), .req1_op1_i(a1), .req1_op2_i(b1), .req1_tag_i(t1),
    .flush_i(flush), .mul_start_o(start), .mul_op1_o(mop1), .mul_op2_o(mop2),
    .mul_result_i(mres),
    .res0_valid_o(r0v), .res0_data_o(r0d), .res0_tag_o(r0t),
    .res1_valid_o(r1v), .res1_data_o(r1d), .res1_tag_o(r1t),
    .busy_o(busy), .inflight_cnt_o(cnt)
  );

  logic [63:0] mp [LAT];
  always @(posedge clk) begin
    mp[0] <= start ? ({32'd0, mop1} * {32'd0, mop2}) : 64'd0;
    for (int i = 1; i < LAT; i++) mp[i] <= mp[i-1];
  end
  assign mres = mp[LAT-1];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    v0 = 0; v1 = 0; flush = 0;
    a0 = 0; b0 = 0; t0 = 0; a1 = 0; b1 = 0; t1 = 0;
  endtask

  task automatic do_reset();
    quiet();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  typedef struct {
    bit          own;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  tag;
    logic [63:0] prod;
  } vec_t;

  vec_t vt [5];

  int ca0 [2] = '{2, 6};
  int cb0 [2] = '{3, 7};
  int ca1 [2] = '{4, 8};
  int cb1 [2] = '{5, 9};
  int exp_cnt [9] = '{0, 1, 2, 3, 3, 2, 1, 0, 0};

  initial begin
    vt[0] = '{1'b0, 32'h3FC00000, 32'h40000000, 5'd5,  64'h0FF0000000000000};
    vt[1] = '{1'b1, 32'd3,        32'd5,        5'd17, 64'd15};
    vt[2] = '{1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd31, 64'hFFFFFFFE00000001};
    vt[3] = '{1'b1, 32'h00010000, 32'h00010000, 5'd0,  64'h0000000100000000};
    vt[4] = '{1'b0, 32'd0,        32'h1234,     5'd10, 64'd0};

    quiet();
    rst_n = 1'b0;
    #1;
    chk("rst_res0_valid", r0v, 0);
    chk("rst_res1_valid", r1v, 0);
    chk("rst_res0_data", r0d, 0);
    chk("rst_res1_tag", r1t, 0);
    chk("rst_inflight", cnt, 0);
    chk("rst_busy", busy, 0);
    do_reset();

    // single operations on either port
    foreach (vt[i]) begin
      if (vt[i].own) begin v1 = 1; a1 = vt[i].a; b1 = vt[i].b; t1 = vt[i].tag; end
      else           begin v0 = 1; a0 = vt[i].a; b0 = vt[i].b; t0 = vt[i].tag; end
      #1;
      chk("vec_ready_own", vt[i].own ? rdy1 : rdy0, 1);
      chk("vec_ready_other", vt[i].own ? rdy0 : rdy1, 0);
      chk("vec_start", start, 1);
      chk("vec_op1", mop1, vt[i].a);
      chk("vec_op2", mop2, vt[i].b);
      step();
      v0 = 0; v1 = 0;
      step(); step();
      chk("vec_early", vt[i].own ? r1v : r0v, 0);
      step();
      chk("vec_res_valid", vt[i].own ? r1v : r0v, 1);
      chk("vec_res_data", vt[i].own ? r1d : r0d, vt[i].prod);
      chk("vec_res_tag", vt[i].own ? r1t : r0t, vt[i].tag);
      chk("vec_other_valid", vt[i].own ? r0v : r1v, 0);
      chk("vec_busy", busy, 1);
      step();
      chk("vec_pulse_end", vt[i].own ? r1v : r0v, 0);
    end

    // contention straight after reset: grants 0,1,0,1
    do_reset();
    begin
      int i0 = 0;
      int i1 = 0;
      for (int c = 0; c < 9; c++) begin
        v0 = (i0 < 2); a0 = v0 ? ca0[i0] : 0; b0 = v0 ? cb0[i0] : 0; t0 = TW'(i0 + 1);
        v1 = (i1 < 2); a1 = v1 ? ca1[i1] : 0; b1 = v1 ? cb1[i1] : 0; t1 = TW'(i1 + 3);
        #1;
        chk("cont_ready0", rdy0, (c == 0 || c == 2));
        chk("cont_ready1", rdy1, (c == 1 || c == 3));
        chk("cont_inflight", cnt, exp_cnt[c]);
        chk("cont_res0_valid", r0v, (c == 4 || c == 6));
        chk("cont_res1_valid", r1v, (c == 5 || c == 7));
        if (c == 4) begin chk("cont_r0_d0", r0d, 6);  chk("cont_r0_t0", r0t, 1); end
        if (c == 6) begin chk("cont_r0_d1", r0d, 42); chk("cont_r0_t1", r0t, 2); end
        if (c == 5) begin chk("cont_r1_d0", r1d, 20); chk("cont_r1_t0", r1t, 3); end
        if (c == 7) begin chk("cont_r1_d1", r1d, 72); chk("cont_r1_t1", r1t, 4); end
        if (rdy0) i0++;
        if (rdy1) i1++;
        step();
      end
      quiet();
    end

    // back-to-back req1, six ops with no bubbles
    for (int c = 0; c < 12; c++) begin
      v1 = (c < 6); a1 = 32'(c + 1); b1 = 32'd3; t1 = TW'(c);
      if (c >= 6) begin a1 = 0; b1 = 0; end
      #1;
      if (c < 6) chk("b2b_ready1", rdy1, 1);
      chk("b2b_res1_valid", r1v, (c >= 4 && c <= 9));
      chk("b2b_res0_valid", r0v, 0);
      if (c >= 4 && c <= 9) begin
        chk("b2b_tag", r1t, TW'(c - 4));
        chk("b2b_data", r1d, 64'((c - 3) * 3));
      end
      step();
    end
    quiet();

    // idle: operands hold the last launched pair (6 x 3)
    for (int c = 0; c < 20; c++) begin
      chk("idle_start", start, 0);
      chk("idle_op1", mop1, 6);
      chk("idle_op2", mop2, 3);
      chk("idle_busy", busy, 0);
      step();
    end

    // flush kills req0 work, req1 proceeds
    for (int c = 0; c < 10; c++) begin
      quiet();
      if (c == 0) begin v0 = 1; a0 = 1; b0 = 1; t0 = 1; end
      if (c == 1) begin v0 = 1; a0 = 2; b0 = 2; t0 = 2; end
      if (c == 2) begin v0 = 1; a0 = 3; b0 = 3; t0 = 3; v1 = 1; a1 = 7; b1 = 7; t1 = 9; flush = 1; end
      #1;
      if (c < 2) chk("fl_ready0_pre", rdy0, 1);
      if (c == 2) begin
        chk("fl_ready0_flush", rdy0, 0);
        chk("fl_ready1_flush", rdy1, 1);
      end
      if (c == 3) chk("fl_inflight", cnt, 1);
      chk("fl_res0_valid", r0v, 0);
      chk("fl_res1_valid", r1v, (c == 6));
      if (c == 6) begin
        chk("fl_res1_tag", r1t, 9);
        chk("fl_res1_data", r1d, 49);
      end
      step();
    end
    quiet();

    // asynchronous reset with three ops in flight
    for (int c = 0; c < 3; c++) begin
      v0 = 1; a0 = 2; b0 = 32'(c + 1); t0 = TW'(c + 20);
      step();
    end
    quiet();
    chk("ar_busy_before", busy, 1);
    chk("ar_inflight_before", cnt, 3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_inflight", cnt, 0);
    chk("ar_busy", busy, 0);
    chk("ar_res0_valid", r0v, 0);
    chk("ar_res0_data", r0d, 0);
    chk("ar_res0_tag", r0t, 0);
    #10;
    rst_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      step();
      chk("ar_post_res0", r0v, 0);
      chk("ar_post_res1", r1v, 0);
      chk("ar_post_busy", busy, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
